// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC sequencing, single-outstanding imem request,
// one-entry instruction register toward decode, redirect and misalignment fault.
module fetch_unit #(
  parameter int ADDRESS_INSTRUCCION = 32,
  parameter logic [ADDRESS_INSTRUCCION-1:0] RESET_VECTOR = '0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [ADDRESS_INSTRUCCION-1:0] pc_in,
  input  logic                           redirect_valid,
  input  logic [ADDRESS_INSTRUCCION-1:0] redirect_addr,
  output logic                           imem_req,
  output logic [ADDRESS_INSTRUCCION-1:0] imem_addr,
  input  logic                           imem_ack,
  input  logic [ADDRESS_INSTRUCCION-1:0] imem_rdata,
  output logic                           instr_valid,
  output logic [ADDRESS_INSTRUCCION-1:0] instr,
  output logic [ADDRESS_INSTRUCCION-1:0] instr_pc,
  input  logic                           stall_in,
  output logic                           fault
);
  localparam int W = ADDRESS_INSTRUCCION;

  typedef enum logic [1:0] {IDLE, REQ, FAULT} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   pc_q, pc_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   instr_q, instr_d;
  logic [W-1:0]   ipc_q, ipc_d;
  logic           jump;
  logic [W-1:0]   jump_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_VECTOR;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    ipc_d     = ipc_q;
    imem_req  = 1'b0;
    jump      = 1'b0;
    jump_addr = pc_in;
    case (state_q)
      IDLE, FAULT: begin
        // redirect is ignored here; only start leaves these states
        if (start) begin
          if (pc_in[1:0] == 2'b00) begin
            state_d = REQ;
            pc_d    = pc_in;
          end else begin
            state_d = FAULT;
          end
        end
      end
      REQ: begin
        // start behaves as a redirect to pc_in and beats redirect_valid
        jump      = start || redirect_valid;
        jump_addr = start ? pc_in : redirect_addr;
        imem_req  = !jump && (!valid_q || !stall_in);
        if (jump) begin
          valid_d = 1'b0;
          if (jump_addr[1:0] == 2'b00) pc_d = jump_addr;
          else                         state_d = FAULT;
        end else if (imem_req && imem_ack) begin
          instr_d = imem_rdata;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + W'(4);
        end else if (valid_q && !stall_in) begin
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign fault       = (state_q == FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, async reset sequence, and
// randomized traffic checked against a cycle-level reference model.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] pc_in = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        stall_in = 1'b0;
  logic        fault;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.ADDRESS_INSTRUCCION(32), .RESET_VECTOR(32'h0)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pc_in(pc_in),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .stall_in(stall_in), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        start;
    logic [31:0] pc_in;
    logic        redir;
    logic [31:0] raddr;
    logic        ack;
    logic        stall;
    logic        e_req;
    logic        e_valid;
    logic        e_fault;
    logic [31:0] e_addr;
    logic [31:0] e_ipc;
    logic [31:0] e_instr;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic [31:0] p, input logic r,
                              input logic [31:0] ra, input logic a, input logic st,
                              input logic q, input logic v, input logic f,
                              input logic [31:0] ad, input logic [31:0] ip,
                              input logic [31:0] in);
    vec_t t;
    t.start = s; t.pc_in = p; t.redir = r; t.raddr = ra; t.ack = a; t.stall = st;
    t.e_req = q; t.e_valid = v; t.e_fault = f; t.e_addr = ad; t.e_ipc = ip; t.e_instr = in;
    return t;
  endfunction

  vec_t vt[20];

  // reference model state
  int          m_mode;   // 0 idle, 1 fetching, 2 fault
  logic [31:0] m_pc, m_instr, m_ipc;
  logic        m_valid;

  task automatic check_model(input string tag);
    logic e_req;
    e_req = (m_mode == 1) && !(start || redirect_valid) && (!m_valid || !stall_in);
    chk({tag, " imem_req"}, {31'b0, imem_req}, {31'b0, e_req});
    chk({tag, " instr_valid"}, {31'b0, instr_valid}, {31'b0, m_valid});
    chk({tag, " fault"}, {31'b0, fault}, {31'b0, m_mode == 2});
    if (m_valid) begin
      chk({tag, " instr"}, instr, m_instr);
      chk({tag, " instr_pc"}, instr_pc, m_ipc);
    end
    if (m_mode != 2) chk({tag, " imem_addr"}, imem_addr, m_pc);
  endtask

  task automatic step_model();
    logic        req, jmp;
    logic [31:0] tgt;
    req = (m_mode == 1) && !(start || redirect_valid) && (!m_valid || !stall_in);
    if (m_mode != 1) begin
      if (start) begin
        if (pc_in[1:0] == 0) begin m_mode = 1; m_pc = pc_in; end
        else m_mode = 2;
      end
    end else begin
      jmp = start || redirect_valid;
      tgt = start ? pc_in : redirect_addr;
      if (jmp) begin
        m_valid = 1'b0;
        if (tgt[1:0] == 0) m_pc = tgt; else m_mode = 2;
      end else if (req && imem_ack) begin
        m_instr = imem_rdata; m_ipc = m_pc; m_valid = 1'b1; m_pc = m_pc + 32'd4;
      end else if (m_valid && !stall_in) begin
        m_valid = 1'b0;
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom & 32'h0000_0FFC;
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    if ($urandom_range(0, 15) == 0) a = 32'hFFFF_FFF8;
    return a;
  endfunction

  initial begin
    vt[0]  = mk(1, 32'h0,        0, 0,         1, 0, 0, 0, 0, 32'h0,        0,            0);
    vt[1]  = mk(0, 0,            0, 0,         1, 0, 1, 0, 0, 32'h0,        0,            0);
    vt[2]  = mk(0, 0,            0, 0,         1, 0, 1, 1, 0, 32'h4,        32'h0,        32'hC0DE_0001);
    vt[3]  = mk(0, 0,            0, 0,         1, 0, 1, 1, 0, 32'h8,        32'h4,        32'hC0DE_0002);
    vt[4]  = mk(0, 0,            0, 0,         1, 1, 0, 1, 0, 32'hC,        32'h8,        32'hC0DE_0003);
    vt[5]  = mk(0, 0,            0, 0,         1, 1, 0, 1, 0, 32'hC,        32'h8,        32'hC0DE_0003);
    vt[6]  = mk(0, 0,            0, 0,         1, 1, 0, 1, 0, 32'hC,        32'h8,        32'hC0DE_0003);
    vt[7]  = mk(0, 0,            0, 0,         1, 1, 0, 1, 0, 32'hC,        32'h8,        32'hC0DE_0003);
    vt[8]  = mk(0, 0,            0, 0,         1, 0, 1, 1, 0, 32'hC,        32'h8,        32'hC0DE_0003);
    vt[9]  = mk(0, 0,            1, 32'h100,   1, 0, 0, 1, 0, 32'h10,       32'hC,        32'hC0DE_0008);
    vt[10] = mk(0, 0,            0, 0,         1, 0, 1, 0, 0, 32'h100,      0,            0);
    vt[11] = mk(0, 0,            0, 0,         0, 0, 1, 1, 0, 32'h104,      32'h100,      32'hC0DE_000A);
    vt[12] = mk(1, 32'h2,        0, 0,         0, 0, 0, 0, 0, 32'h104,      0,            0);
    vt[13] = mk(0, 0,            1, 32'h200,   1, 0, 0, 0, 1, 0,            0,            0);
    vt[14] = mk(1, 32'h40,       0, 0,         1, 0, 0, 0, 1, 0,            0,            0);
    vt[15] = mk(0, 0,            0, 0,         1, 0, 1, 0, 0, 32'h40,       0,            0);
    vt[16] = mk(1, 32'hFFFF_FFFC,0, 0,         1, 0, 0, 1, 0, 32'h44,       32'h40,       32'hC0DE_000F);
    vt[17] = mk(0, 0,            0, 0,         1, 0, 1, 0, 0, 32'hFFFF_FFFC,0,            0);
    vt[18] = mk(0, 0,            0, 0,         1, 0, 1, 1, 0, 32'h0,        32'hFFFF_FFFC,32'hC0DE_0011);
    vt[19] = mk(0, 0,            0, 0,         0, 0, 1, 1, 0, 32'h4,        32'h0,        32'hC0DE_0012);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst imem_req", {31'b0, imem_req}, 0);
    chk("rst imem_addr", imem_addr, 32'h0);
    chk("rst instr_valid", {31'b0, instr_valid}, 0);
    chk("rst fault", {31'b0, fault}, 0);
    chk("rst instr", instr, 0);
    chk("rst instr_pc", instr_pc, 0);
    @(negedge clk) reset_n = 1'b1;

    // directed table
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = vt[i].start; pc_in = vt[i].pc_in;
      redirect_valid = vt[i].redir; redirect_addr = vt[i].raddr;
      imem_ack = vt[i].ack; stall_in = vt[i].stall;
      imem_rdata = 32'hC0DE_0000 | 32'(i);
      #1;
      chk($sformatf("v%0d imem_req", i), {31'b0, imem_req}, {31'b0, vt[i].e_req});
      chk($sformatf("v%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, vt[i].e_valid});
      chk($sformatf("v%0d fault", i), {31'b0, fault}, {31'b0, vt[i].e_fault});
      if (!vt[i].e_fault) chk($sformatf("v%0d imem_addr", i), imem_addr, vt[i].e_addr);
      if (vt[i].e_valid) begin
        chk($sformatf("v%0d instr_pc", i), instr_pc, vt[i].e_ipc);
        chk($sformatf("v%0d instr", i), instr, vt[i].e_instr);
      end
    end

    // asynchronous reset in the middle of a request
    @(negedge clk);
    start = 1'b1; pc_in = 32'h20; redirect_valid = 1'b0; imem_ack = 1'b1; stall_in = 1'b0;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async imem_req", {31'b0, imem_req}, 0);
    chk("async imem_addr", imem_addr, 32'h0);
    chk("async instr_valid", {31'b0, instr_valid}, 0);
    chk("async fault", {31'b0, fault}, 0);
    chk("async instr", instr, 0);
    chk("async instr_pc", instr_pc, 0);
    @(negedge clk) reset_n = 1'b1;
    // late acks after reset are ignored in IDLE
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("idle ack imem_req", {31'b0, imem_req}, 0);
      chk("idle ack instr_valid", {31'b0, instr_valid}, 0);
      chk("idle ack imem_addr", imem_addr, 32'h0);
    end

    // randomized traffic against the reference model
    m_mode = 0; m_pc = 32'h0; m_valid = 1'b0; m_instr = '0; m_ipc = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start          = ($urandom_range(0, 39) == 0);
      pc_in          = rand_addr();
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_addr  = rand_addr();
      imem_ack       = ($urandom_range(0, 2) != 0);
      stall_in       = ($urandom_range(0, 2) == 0);
      imem_rdata     = $urandom;
      #1;
      check_model($sformatf("rnd%0d", c));
      @(posedge clk);
      step_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDRESS_INSTRUCCION, default 32, SHALL set the width of every address and instruction bus.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL be the PC value loaded by reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL be a one-cycle pulse that loads pc_in and begins fetching.
REQ-006 pc_in  input  ADDRESS_INSTRUCCION  SHALL be the start address, sampled only when start=1.
REQ-007 redirect_valid  input  1  SHALL request a branch/jump redirect.
REQ-008 redirect_addr  input  ADDRESS_INSTRUCCION  SHALL be the redirect target.
REQ-009 imem_req  output  1  SHALL be the instruction-memory read request.
REQ-010 imem_addr  output  ADDRESS_INSTRUCCION  SHALL be the registered fetch address; it equals the internal PC.
REQ-011 imem_ack  input  1  SHALL indicate imem_rdata is valid for the current request.
REQ-012 imem_rdata  input  ADDRESS_INSTRUCCION  SHALL carry the fetched instruction word.
REQ-013 instr_valid  output  1  SHALL indicate that instr/instr_pc hold an instruction for decode.
REQ-014 instr  output  ADDRESS_INSTRUCCION  SHALL hold the registered instruction word.
REQ-015 instr_pc  output  ADDRESS_INSTRUCCION  SHALL hold the address that instr was fetched from.
REQ-016 stall_in  input  1  SHALL indicate that decode is not accepting; instr is consumed on a cycle with instr_valid=1 and stall_in=0.
REQ-017 fault  output  1  SHALL flag a misaligned fetch address.

Function
REQ-018 The FSM SHALL have three states: IDLE, REQ, and FAULT.
REQ-019 IDLE: imem_req=0. On start with pc_in[1:0]==0, the block SHALL set PC<=pc_in and move to REQ. On start with pc_in[1:0]!=0, it SHALL move to FAULT.
REQ-020 REQ: imem_req SHALL be combinationally (state==REQ) && (!instr_valid || !stall_in).
REQ-021 Rule for REQ-020: a response is never accepted while an unconsumed instruction is held.
REQ-022 imem_addr SHALL stay stable while imem_req=1 and imem_ack=0.
REQ-023 On imem_req && imem_ack, all of the following SHALL be registered in the same edge:
  - instr<=imem_rdata
  - instr_pc<=PC
  - instr_valid<=1
  - PC<=PC+4, modulo 2^ADDRESS_INSTRUCCION (32'hFFFF_FFFC wraps to 0)
  - state remains REQ
REQ-024 Back-to-back fetch: with imem_ack tied high and stall_in=0, the block SHALL deliver one instruction per cycle; first instr_valid appears 2 cycles after the start pulse.
REQ-025 When instr is consumed and no new ack is accepted in the same cycle, instr_valid SHALL clear on the next edge.
REQ-026 While instr_valid=1 and stall_in=1, instr and instr_pc SHALL hold unchanged.
REQ-027 redirect_valid in state REQ SHALL have priority over imem_ack and stall_in. On that edge the block SHALL:
  - set PC<=redirect_addr
  - set instr_valid<=0
  - discard any ack in that cycle
  - drive imem_req=0 during the redirect cycle
REQ-028 After a redirect, fetch SHALL resume at redirect_addr on the next cycle.
REQ-029 redirect_valid in IDLE or FAULT SHALL be ignored.
REQ-030 A redirect with redirect_addr[1:0]!=0 SHALL move the block to FAULT.
REQ-031 FAULT SHALL force imem_req=0, instr_valid=0, and fault=1.
REQ-032 The only exits from FAULT SHALL be reset, or start with an aligned pc_in, which goes to REQ and clears fault.
REQ-033 start in state REQ SHALL act exactly as a redirect to pc_in. When start and redirect_valid are both asserted, start SHALL win.

Reset
REQ-034 reset_n=0 SHALL immediately, without waiting for clk, force:
  - state=IDLE
  - PC=imem_addr=RESET_VECTOR
  - imem_req=0, instr_valid=0, fault=0
  - instr=0, instr_pc=0
REQ-035 Reset asserted mid-request SHALL abandon the outstanding fetch. An imem_ack arriving after reset releases SHALL be ignored while the block is in IDLE.

Verification
REQ-036 Reset for 3 cycles, then start with pc_in=0x0000_0000, imem_ack=1, stall_in=0 -> instr_pc sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles.
REQ-037 With instr_valid=1 at instr_pc=0x8, hold stall_in=1 for 4 cycles -> instr/instr_pc frozen and imem_req=0; release -> 0xC follows on the next cycle.
REQ-038 Redirect to 0x0000_0100 in the same cycle as imem_ack -> ack data dropped, instr_valid=0 next cycle, imem_addr=0x100, next instr_pc=0x100.
REQ-039 start with pc_in=0x0000_0002 -> fault=1, imem_req=0; then start with pc_in=0x40 -> fault=0 and fetch from 0x40.
REQ-040 start with pc_in=0xFFFF_FFFC and ack high -> instr_pc 0xFFFF_FFFC, then 0x0000_0000.
REQ-041 Assert reset_n low between clock edges during REQ -> all outputs reach their reset values before the next edge.
